// File: rtl/game_state_pkg.sv
// Shared constants and types for the CPU-side game-state writer.
package game_state_pkg;

  localparam int WORD_W = 32;

  // Word-address map of the CPU port.
  localparam int BULLET_BASE = 0;
  localparam int SPRITE_BASE = 64;
  localparam int HEALTH_BASE = 68;
  localparam int CTRL_ADDR   = 70;
  localparam int STATUS_ADDR = 71;

  // Bullet word layout; carried through untouched, documented here for game code.
  localparam int BULLET_X_MSB   = 31;
  localparam int BULLET_X_LSB   = 22;
  localparam int BULLET_Y_MSB   = 21;
  localparam int BULLET_Y_LSB   = 13;
  localparam int BULLET_ACT_BIT = 2;

  // Commit FSM: the state bit itself is exported as commitPending.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/state_shadow_bank.sv
// One shadow/live word bank: CPU writes land in shadow, a commit copies
// the whole shadow array into the live array in a single cycle.
module state_shadow_bank
  import game_state_pkg::*;
#(
  parameter int NUM_WORDS  = 4,
  parameter int BASE       = 0,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,   // accepted CPU write this cycle
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic [WORD_W-1:0]           wdata_i,
  input  logic                        commit_i,  // copy shadow -> live on this edge
  output logic [WORD_W-1:0]           rd_data_o, // shadow word at addr_i, 0 if out of range
  output logic [WORD_W*NUM_WORDS-1:0] live_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE);

  logic [WORD_W*NUM_WORDS-1:0] shadow_q, shadow_d;
  logic [WORD_W*NUM_WORDS-1:0] live_q, live_d;
  logic [ADDR_WIDTH-1:0]       off;

  // Offset relative to the bank base; wraps for addresses below the base,
  // so an out-of-range address simply never matches a slot.
  assign off = addr_i - BASE_A;

  // Shadow write decode, commit copy and read selection.
  always_comb begin
    shadow_d  = shadow_q;
    live_d    = commit_i ? shadow_q : live_q;
    rd_data_o = '0;
    for (int j = 0; j < NUM_WORDS; j++) begin
      if (off == ADDR_WIDTH'(j)) begin
        rd_data_o = shadow_q[j*WORD_W +: WORD_W];
        if (wr_en_i) shadow_d[j*WORD_W +: WORD_W] = wdata_i;
      end
    end
  end

  // Bank storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign live_o = live_q;

endmodule

// File: rtl/game_state_writer.sv
// CPU-side writer for the display's packed game-state buses. Stores go to a
// shadow bank; a CTRL request arms a commit that copies shadow to live on the
// next screenEnd, so the display never sees a half-written frame.
// Handshake: a write is accepted on a rising clk edge iff wEn && wReady; the
// CPU holds wEn/addr/wData stable until then. wReady is low while a commit
// is pending.
module game_state_writer
  import game_state_pkg::*;
#(
  parameter int NUM_BULLETS      = 64,
  parameter int NUM_SPRITE_WORDS = 4,
  parameter int NUM_HEALTH_WORDS = 2,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                               clk,
  input  logic                               CPU_RESETN,
  input  logic                               wEn,
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [WORD_W-1:0]                  wData,
  output logic                               wReady,
  output logic [WORD_W-1:0]                  rData,
  input  logic                               screenEnd,
  output logic [WORD_W*NUM_BULLETS-1:0]      allBulletContents,
  output logic [WORD_W*NUM_SPRITE_WORDS-1:0] allSpriteContents,
  output logic [WORD_W*NUM_HEALTH_WORDS-1:0] allHealthContents,
  output logic                               commitPending,
  output logic [15:0]                        frameCount
);

  commit_state_e     state_q, state_d;
  logic              accept;
  logic              ctrl_req;
  logic              commit;
  logic [15:0]       frame_q, frame_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] bullet_rd, sprite_rd, health_rd;

  assign wReady   = (state_q == ST_IDLE);
  assign accept   = wEn && wReady;
  assign ctrl_req = accept && (addr == ADDR_WIDTH'(CTRL_ADDR)) && wData[0];

  // Commit FSM next state; a CTRL write coinciding with screenEnd only arms.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE:    if (ctrl_req) state_d = ST_PENDING;
      ST_PENDING: if (screenEnd) begin
        state_d = ST_IDLE;
        commit  = 1'b1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Frame counter advances on every screenEnd, wrapping naturally.
  always_comb begin
    frame_d = screenEnd ? frame_q + 16'd1 : frame_q;
  end

  // Read mux: banks return 0 outside their range; STATUS is assembled here.
  always_comb begin
    rdata_d = bullet_rd | sprite_rd | health_rd;
    if (addr == ADDR_WIDTH'(STATUS_ADDR)) rdata_d = {frame_q, 15'b0, commitPending};
  end

  // FSM state, frame counter and registered read data.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
    end
  end

  assign commitPending = (state_q == ST_PENDING);
  assign frameCount    = frame_q;
  assign rData         = rdata_q;

  state_shadow_bank #(.NUM_WORDS(NUM_BULLETS), .BASE(BULLET_BASE), .ADDR_WIDTH(ADDR_WIDTH)) u_bullets (
    .clk_i(clk), .rst_ni(CPU_RESETN), .wr_en_i(accept), .addr_i(addr), .wdata_i(wData),
    .commit_i(commit), .rd_data_o(bullet_rd), .live_o(allBulletContents)
  );

  state_shadow_bank #(.NUM_WORDS(NUM_SPRITE_WORDS), .BASE(SPRITE_BASE), .ADDR_WIDTH(ADDR_WIDTH)) u_sprites (
    .clk_i(clk), .rst_ni(CPU_RESETN), .wr_en_i(accept), .addr_i(addr), .wdata_i(wData),
    .commit_i(commit), .rd_data_o(sprite_rd), .live_o(allSpriteContents)
  );

  state_shadow_bank #(.NUM_WORDS(NUM_HEALTH_WORDS), .BASE(HEALTH_BASE), .ADDR_WIDTH(ADDR_WIDTH)) u_health (
    .clk_i(clk), .rst_ni(CPU_RESETN), .wr_en_i(accept), .addr_i(addr), .wdata_i(wData),
    .commit_i(commit), .rd_data_o(health_rd), .live_o(allHealthContents)
  );

endmodule

// File: tb/tb_game_state_writer.sv
// Directed bench for game_state_writer: shadow writes, commit timing,
// write stalls, CTRL/screenEnd collision, unmapped addresses, STATUS,
// frame counter wrap and asynchronous reset.
module tb_game_state_writer;

  logic          clk = 1'b0;
  logic          CPU_RESETN = 1'b0;
  logic          wEn = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   wData = '0;
  logic          wReady;
  logic [31:0]   rData;
  logic          screenEnd = 1'b0;
  logic [2047:0] allBulletContents;
  logic [127:0]  allSpriteContents;
  logic [63:0]   allHealthContents;
  logic          commitPending;
  logic [15:0]   frameCount;

  int checks = 0;
  int errors = 0;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  game_state_writer dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .wEn(wEn), .addr(addr), .wData(wData),
    .wReady(wReady), .rData(rData), .screenEnd(screenEnd),
    .allBulletContents(allBulletContents), .allSpriteContents(allSpriteContents),
    .allHealthContents(allHealthContents), .commitPending(commitPending),
    .frameCount(frameCount)
  );

  // Driver: hold a write until accepted (bounded), then release.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    int cnt = 0;
    addr = a; wData = d; wEn = 1'b1;
    while (!wReady && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    checks++;
    if (!wReady) begin
      $display("FAIL write_accept_timeout addr=%0d wReady=%b required 1", a, wReady);
      errors++;
    end
    @(posedge clk); #1;
    wEn = 1'b0;
  endtask

  // Driver: one-cycle screenEnd pulse.
  task automatic pulse_screen();
    screenEnd = 1'b1;
    @(posedge clk); #1;
    screenEnd = 1'b0;
  endtask

  // Driver: present a read address, return rData one cycle later.
  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    wEn = 1'b0; addr = a;
    @(posedge clk); #1;
    d = rData;
  endtask

  task automatic apply_reset();
    wEn = 1'b0; screenEnd = 1'b0; addr = '0; wData = '0;
    #2 CPU_RESETN = 1'b0;
    repeat (2) @(posedge clk);
    #1 CPU_RESETN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (wReady !== 1'b1) begin $display("FAIL reset_wready got %b exp 1", wReady); errors++; end
    checks++; if (rData !== 32'h0) begin $display("FAIL reset_rdata got %h exp 0", rData); errors++; end
    checks++; if (commitPending !== 1'b0) begin $display("FAIL reset_pending got %b exp 0", commitPending); errors++; end
    checks++; if (frameCount !== 16'h0) begin $display("FAIL reset_frame got %h exp 0", frameCount); errors++; end
    checks++; if (allBulletContents !== '0 || allSpriteContents !== '0 || allHealthContents !== '0) begin
      $display("FAIL reset_live nonzero live bank, exp all 0"); errors++;
    end
  endtask

  task automatic test_shadow_write();
    logic [31:0] d;
    do_write(12'd0, 32'h1900_2004);
    do_write(12'd64, 32'h0000_0050);
    do_read(12'd0, d);
    checks++; if (d !== 32'h1900_2004) begin $display("FAIL shadow_rd0 got %h exp 19002004", d); errors++; end
    do_read(12'd64, d);
    checks++; if (d !== 32'h0000_0050) begin $display("FAIL shadow_rd64 got %h exp 00000050", d); errors++; end
    checks++; if (allBulletContents !== '0 || allSpriteContents !== '0) begin
      $display("FAIL live_before_commit bullet0=%h sprite0=%h exp 0", allBulletContents[31:0], allSpriteContents[31:0]); errors++;
    end
  endtask

  task automatic test_commit();
    do_write(12'd70, 32'h1);
    for (int i = 0; i < 10; i++) begin
      checks++; if (commitPending !== 1'b1 || wReady !== 1'b0) begin
        $display("FAIL pending_window cyc=%0d pending=%b wReady=%b exp 1/0", i, commitPending, wReady); errors++;
      end
      checks++; if (allBulletContents[31:0] !== 32'h0) begin
        $display("FAIL live_while_pending got %h exp 0", allBulletContents[31:0]); errors++;
      end
      @(posedge clk); #1;
    end
    pulse_screen();
    checks++; if (allBulletContents[31:0] !== 32'h1900_2004) begin $display("FAIL commit_bullet got %h exp 19002004", allBulletContents[31:0]); errors++; end
    checks++; if (allSpriteContents[31:0] !== 32'h50) begin $display("FAIL commit_sprite got %h exp 50", allSpriteContents[31:0]); errors++; end
    checks++; if (commitPending !== 1'b0 || wReady !== 1'b1) begin $display("FAIL commit_clear pending=%b wReady=%b exp 0/1", commitPending, wReady); errors++; end
    checks++; if (frameCount !== 16'd1) begin $display("FAIL commit_frame got %0d exp 1", frameCount); errors++; end
  endtask

  task automatic test_stall();
    do_write(12'd70, 32'h1);
    addr = 12'd68; wData = 32'h3; wEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wReady !== 1'b0) begin $display("FAIL stall_wready got %b exp 0", wReady); errors++; end
      @(posedge clk); #1;
      checks++; if (rData !== 32'h0) begin $display("FAIL stall_no_accept rdata=%h exp 0", rData); errors++; end
    end
    screenEnd = 1'b1;
    @(posedge clk); #1;
    screenEnd = 1'b0;
    checks++; if (allHealthContents !== 64'h0) begin $display("FAIL stall_live_health got %h exp 0", allHealthContents); errors++; end
    checks++; if (allBulletContents[31:0] !== 32'h1900_2004) begin $display("FAIL stall_live_bullet got %h exp 19002004", allBulletContents[31:0]); errors++; end
    checks++; if (wReady !== 1'b1 || rData !== 32'h0) begin $display("FAIL stall_release wReady=%b rdata=%h exp 1/0", wReady, rData); errors++; end
    @(posedge clk); #1;
    checks++; if (rData !== 32'h0) begin $display("FAIL rw_same_cycle_old got %h exp 0", rData); errors++; end
    wEn = 1'b0;
    @(posedge clk); #1;
    checks++; if (rData !== 32'h3) begin $display("FAIL stall_accepted got %h exp 3", rData); errors++; end
    checks++; if (allHealthContents !== 64'h0) begin $display("FAIL live_health_stable got %h exp 0", allHealthContents); errors++; end
    checks++; if (frameCount !== 16'd2) begin $display("FAIL stall_frame got %0d exp 2", frameCount); errors++; end
  endtask

  task automatic test_ctrl_on_screen_end();
    addr = 12'd70; wData = 32'h1; wEn = 1'b1; screenEnd = 1'b1;
    @(posedge clk); #1;
    wEn = 1'b0; screenEnd = 1'b0;
    checks++; if (commitPending !== 1'b1) begin $display("FAIL collide_pending got %b exp 1", commitPending); errors++; end
    checks++; if (allHealthContents !== 64'h0) begin $display("FAIL collide_no_commit got %h exp 0", allHealthContents); errors++; end
    checks++; if (frameCount !== 16'd3) begin $display("FAIL collide_frame got %0d exp 3", frameCount); errors++; end
    repeat (2) @(posedge clk);
    #1;
    pulse_screen();
    checks++; if (allHealthContents !== 64'h3) begin $display("FAIL collide_commit got %h exp 3", allHealthContents); errors++; end
    checks++; if (commitPending !== 1'b0 || frameCount !== 16'd4) begin
      $display("FAIL collide_after pending=%b frame=%0d exp 0/4", commitPending, frameCount); errors++;
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    do_write(12'd200, 32'hDEAD_BEEF);
    checks++; if (allBulletContents[31:0] !== 32'h1900_2004 || allSpriteContents !== 128'h50 || allHealthContents !== 64'h3) begin
      $display("FAIL unmapped_live bullet0=%h sprite=%h health=%h", allBulletContents[31:0], allSpriteContents, allHealthContents); errors++;
    end
    do_read(12'd200, d);
    checks++; if (d !== 32'h0) begin $display("FAIL unmapped_read got %h exp 0", d); errors++; end
    do_read(12'd0, d);
    checks++; if (d !== 32'h1900_2004) begin $display("FAIL unmapped_shadow0 got %h exp 19002004", d); errors++; end
    do_read(12'd64, d);
    checks++; if (d !== 32'h50) begin $display("FAIL unmapped_shadow64 got %h exp 50", d); errors++; end
    do_read(12'd69, d);
    checks++; if (d !== 32'h0) begin $display("FAIL unmapped_shadow69 got %h exp 0", d); errors++; end
    do_read(12'd72, d);
    checks++; if (d !== 32'h0) begin $display("FAIL unmapped_read72 got %h exp 0", d); errors++; end
  endtask

  task automatic test_status();
    logic [31:0] d;
    apply_reset();
    repeat (3) pulse_screen();
    do_read(12'd71, d);
    checks++; if (d !== 32'h0003_0000) begin $display("FAIL status_idle got %h exp 00030000", d); errors++; end
    do_write(12'd70, 32'h1);
    do_read(12'd71, d);
    checks++; if (d !== 32'h0003_0001) begin $display("FAIL status_pending got %h exp 00030001", d); errors++; end
    do_read(12'd70, d);
    checks++; if (d !== 32'h0) begin $display("FAIL ctrl_read got %h exp 0", d); errors++; end
    pulse_screen();
    do_write(12'd70, 32'h0);
    checks++; if (commitPending !== 1'b0) begin $display("FAIL ctrl_zero got %b exp 0", commitPending); errors++; end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    screenEnd = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (frameCount !== 16'hFFFF) begin $display("FAIL frame_max got %h exp ffff", frameCount); errors++; end
    @(posedge clk); #1;
    screenEnd = 1'b0;
    checks++; if (frameCount !== 16'h0000) begin $display("FAIL frame_wrap got %h exp 0000", frameCount); errors++; end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_write(12'd1, 32'hAAAA_5555);
    do_write(12'd70, 32'h1);
    pulse_screen();
    checks++; if (allBulletContents[63:32] !== 32'hAAAA_5555) begin $display("FAIL pre_reset_live got %h exp aaaa5555", allBulletContents[63:32]); errors++; end
    do_write(12'd70, 32'h1);
    #3 CPU_RESETN = 1'b0;
    #1;
    checks++; if (allBulletContents !== '0 || allSpriteContents !== '0 || allHealthContents !== '0) begin
      $display("FAIL async_live bullet1=%h exp 0", allBulletContents[63:32]); errors++;
    end
    checks++; if (commitPending !== 1'b0 || frameCount !== 16'h0 || wReady !== 1'b1 || rData !== 32'h0) begin
      $display("FAIL async_ctrl pending=%b frame=%h wReady=%b rdata=%h exp 0/0/1/0", commitPending, frameCount, wReady, rData); errors++;
    end
    @(posedge clk); #1 CPU_RESETN = 1'b1;
    do_read(12'd1, d);
    checks++; if (d !== 32'h0) begin $display("FAIL async_shadow got %h exp 0", d); errors++; end
  endtask

  initial begin
    test_reset();
    test_shadow_write();
    test_commit();
    test_stall();
    test_ctrl_on_screen_end();
    test_unmapped();
    test_status();
    test_async_reset();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_writer.md
Name: game_state_writer

Overview:
- CPU-side writer for the packed game-state buses that the display path reads: bullet words, sprite positions and player health.
- CPU stores land in a shadow bank. On CPU request, the whole bank is copied to the live bank at the next frame boundary (screenEnd), so the display never sees a half-updated frame.
- Sits between the CPU memory-store path and the display controller.
- Adds a status word and a frame counter so game code can pace itself to vblank.

Parameters:
- NUM_BULLETS, 64, bullet slots; each slot is a 32-bit word.
- NUM_SPRITE_WORDS, 4, sprite words in order x1, y1, x2, y2.
- NUM_HEALTH_WORDS, 2, health words in order p1, p2.
- ADDR_WIDTH, 12, word-address width of the CPU port.

Ports:
- clk  in  1  system clock, same clock as the display timing generator.
- CPU_RESETN  in  1  asynchronous active-low reset.
- wEn  in  1  CPU write strobe.
- addr  in  ADDR_WIDTH  CPU word address, used for both writes and reads.
- wData  in  32  CPU write data.
- wReady  out  1  write accepted this cycle when wEn && wReady.
- rData  out  32  registered read data for addr.
- screenEnd  in  1  one-cycle pulse between frames, from the timing generator.
- allBulletContents  out  32*NUM_BULLETS  live bank; slot j occupies bits [j*32 +: 32].
- allSpriteContents  out  32*NUM_SPRITE_WORDS  live bank.
- allHealthContents  out  32*NUM_HEALTH_WORDS  live bank; p1 in [31:0].
- commitPending  out  1  commit requested, not yet performed.
- frameCount  out  16  number of screenEnd pulses seen since reset.

Behaviour:
- Reset is asynchronous on CPU_RESETN low. All shadow words, all live words, rData, commitPending and frameCount go to 0. wReady goes to 1.
- Address map (word addresses):
  - 0..63: bullet shadow.
  - 64..67: sprite shadow.
  - 68..69: health shadow.
  - 70: CTRL. Writing with wData[0]=1 requests a commit; wData[0]=0 has no effect.
  - 71: STATUS, read-only. {frameCount[15:0], 15'b0, commitPending}.
  - All other addresses: writes ignored, reads return 0.
- Write handshake:
  - A write is accepted only when wEn && wReady; the CPU holds wEn, addr and wData until accepted.
  - wReady = !commitPending (combinational). Shadow writes stall while a commit is pending.
  - An accepted write updates the shadow word on the same clock edge.
- Reads:
  - rData is registered with 1-cycle latency: rData(t+1) = contents(addr(t)).
  - Data, bullet, sprite and health addresses return the shadow word.
  - A read and a write to the same address in one cycle return the old value.
- Commit state machine, two states:
  - IDLE to PENDING on an accepted CTRL write with bit0=1.
  - PENDING to IDLE on screenEnd. On that edge every live word is loaded from its shadow word in a single cycle.
  - A CTRL write in IDLE that coincides with screenEnd moves to PENDING only. It does not commit on that pulse; the commit happens at the following screenEnd.
  - CTRL writes during PENDING are never accepted, because wReady=0.
- frameCount increments on every screenEnd, independent of commits, and wraps 0xFFFF to 0x0000.
- Live outputs change only on a commit edge or on reset. They are stable for the whole active frame.
- Reset during PENDING drops the pending commit; live and shadow banks both clear to 0.
- Bullet word layout is fixed and not interpreted by this block: X=[31:22], Y=[21:13], active=[2].

Decomposition:
- Shared package game_state_pkg holds:
  - address constants: BULLET_BASE=0, SPRITE_BASE=64, HEALTH_BASE=68, CTRL_ADDR=70, STATUS_ADDR=71;
  - bullet field offsets (31:22, 21:13, 2);
  - word-width constant 32.
- One sub-module, state_shadow_bank, parameterised by word count. It holds the shadow array, the live array, write decode and the commit copy, and is instantiated three times (bullets, sprites, health).
- The top level holds the commit FSM, the frame counter, read mux/register and wReady.

Test Plan:
- Reset, then write addr 0 = 0x1900_2004 and addr 64 = 0x0000_0050 → rData reads back both 1 cycle later. allBulletContents and allSpriteContents stay 0 until a commit.
- Write CTRL=1, then pulse screenEnd 10 cycles later → commitPending is 1 for those 10 cycles and wReady is 0. After the pulse, allBulletContents[31:0]=0x19002004, allSpriteContents[31:0]=0x50 and commitPending=0.
- Hold wEn to addr 68 with 0x3 while PENDING → no accept. After screenEnd, the write is accepted next cycle; live health stays at the committed value until the next commit.
- CTRL write on the same cycle as screenEnd → no commit that frame; commitPending=1; the commit occurs on the second screenEnd.
- Write addr 200 = 0xDEADBEEF → all banks unchanged; read of 200 returns 0. Read of 71 after 3 screenEnd pulses returns 0x0003_0000.
- Assert CPU_RESETN low mid-cycle while PENDING with non-zero shadow → all outputs 0 immediately (asynchronous), commitPending=0, frameCount=0.
